// File: rtl/uart_instr_loader.sv
// uart_instr_loader: receives a framed program image over UART 8N1, writes 32-bit words into
// instruction memory and replies with a one-byte status (K good, E error, T timeout).
module uart_instr_loader #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int INSTR_WIDTH  = 32,
  parameter int INSTR_DEPTH  = 256,
  parameter int TIMEOUT_BITS = 20,
  localparam int AW          = $clog2(INSTR_DEPTH)
) (
  input  logic                   clk,
  input  logic                   loader_rst_n,
  input  logic                   uart_rx,
  output logic                   uart_tx,
  input  logic [AW-1:0]          rd_addr,
  output logic [INSTR_WIDTH-1:0] rd_data,
  output logic                   load_busy,
  output logic                   load_done,
  output logic                   load_err,
  output logic [AW:0]            words_loaded
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int TMO = TIMEOUT_BITS * CPB;
  localparam int TW  = $clog2(TMO + 1);
  localparam int NW  = AW + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_COUNT, P_DATA, P_CHK, P_RESP} p_state_e;

  logic rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_e rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;

  logic [9:0] tx_sh_q, tx_sh_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic tx_busy_q, tx_busy_d;
  logic tx_req;
  logic [7:0] tx_byte;

  p_state_e p_state_q, p_state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [NW-1:0] rem_q, rem_d, words_q, words_d;
  logic [23:0] asm_q, asm_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [7:0] chk_q, chk_d, resp_q, resp_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic mid, tmo_hit, we;
  logic [INSTR_WIDTH-1:0] wdata;
  logic [INSTR_WIDTH-1:0] mem [INSTR_DEPTH];

  always_ff @(posedge clk or negedge loader_rst_n)
    if (!loader_rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_sh_q    <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_busy_q  <= 1'b0;
      p_state_q  <= P_IDLE;
      wr_addr_q  <= '0;
      rem_q      <= '0;
      words_q    <= '0;
      asm_q      <= '0;
      bcnt_q     <= '0;
      chk_q      <= '0;
      resp_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_busy_q  <= tx_busy_d;
      p_state_q  <= p_state_d;
      wr_addr_q  <= wr_addr_d;
      rem_q      <= rem_d;
      words_q    <= words_d;
      asm_q      <= asm_d;
      bcnt_q     <= bcnt_d;
      chk_q      <= chk_d;
      resp_q     <= resp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_s3_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START:
        if (rx_cnt_q == CW'(CPB / 2 - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (rx_cnt_q == CW'(CPB - 1)) begin
          rx_cnt_d   = '0;
          rx_sh_d    = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
        end
      RX_STOP:
        if (rx_cnt_q == CW'(CPB - 1)) begin
          rx_valid_d = rx_s2_q;
          rx_ferr_d  = !rx_s2_q;
          rx_state_d = RX_IDLE;
        end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A request while the shifter is busy is simply dropped.
  always_comb begin
    tx_sh_d   = tx_sh_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    tx_busy_d = tx_busy_q;
    if (!tx_busy_q) begin
      if (tx_req) begin
        tx_sh_d   = {1'b1, tx_byte, 1'b0};
        tx_cnt_d  = '0;
        tx_bit_d  = '0;
        tx_busy_d = 1'b1;
      end
    end else if (tx_cnt_q == CW'(CPB - 1)) begin
      tx_cnt_d  = '0;
      tx_sh_d   = {1'b1, tx_sh_q[9:1]};
      tx_bit_d  = tx_bit_q + 4'd1;
      tx_busy_d = (tx_bit_q != 4'd9);
    end else begin
      tx_cnt_d = tx_cnt_q + CW'(1);
    end
  end

  assign mid     = p_state_q inside {P_ADDR, P_COUNT, P_DATA, P_CHK};
  assign tmo_hit = mid && !rx_valid_q && (tmo_q == TW'(TMO - 1));

  always_comb begin
    p_state_d = p_state_q;
    wr_addr_d = wr_addr_q;
    rem_d     = rem_q;
    words_d   = words_q;
    asm_d     = asm_q;
    bcnt_d    = bcnt_q;
    chk_d     = chk_q;
    resp_d    = resp_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    tmo_d     = (!mid || rx_valid_q) ? '0 : tmo_q + TW'(1);
    tx_req    = 1'b0;
    tx_byte   = resp_q;
    we        = 1'b0;
    wdata     = {asm_q, rx_sh_q};
    if (mid && (rx_ferr_q || tmo_hit)) begin
      err_d     = 1'b1;
      busy_d    = 1'b0;
      tx_req    = 1'b1;
      tx_byte   = rx_ferr_q ? 8'h45 : 8'h54;
      p_state_d = P_IDLE;
    end else begin
      case (p_state_q)
        P_IDLE:
          if (rx_valid_q && rx_sh_q == 8'hA5) begin
            busy_d    = 1'b1;
            err_d     = 1'b0;
            words_d   = '0;
            p_state_d = P_ADDR;
          end
        P_ADDR:
          if (rx_valid_q) begin
            wr_addr_d = AW'(rx_sh_q);
            p_state_d = P_COUNT;
          end
        P_COUNT:
          if (rx_valid_q) begin
            rem_d     = NW'(rx_sh_q) + NW'(1);
            bcnt_d    = '0;
            chk_d     = '0;
            p_state_d = P_DATA;
          end
        P_DATA:
          if (rx_valid_q) begin
            asm_d  = {asm_q[15:0], rx_sh_q};
            chk_d  = chk_q ^ rx_sh_q;
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              we        = 1'b1;
              wr_addr_d = (wr_addr_q == AW'(INSTR_DEPTH - 1)) ? '0 : wr_addr_q + AW'(1);
              words_d   = words_q + NW'(1);
              rem_d     = rem_q - NW'(1);
              p_state_d = (rem_q == NW'(1)) ? P_CHK : P_DATA;
            end
          end
        P_CHK:
          if (rx_valid_q) begin
            done_d    = (rx_sh_q == chk_q);
            err_d     = (rx_sh_q != chk_q);
            resp_d    = (rx_sh_q == chk_q) ? 8'h4B : 8'h45;
            p_state_d = P_RESP;
          end
        P_RESP: begin
          tx_req    = 1'b1;
          busy_d    = 1'b0;
          p_state_d = P_IDLE;
        end
        default: p_state_d = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (we) mem[wr_addr_q] <= wdata;

  assign rd_data      = mem[rd_addr];
  assign uart_tx      = tx_sh_q[0];
  assign load_busy    = busy_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;
endmodule

// File: tb/tb_uart_instr_loader.sv
// tb_uart_instr_loader: directed and random frames against a byte-level frame model and memory image.
module tb_uart_instr_loader;
  localparam int CPB = 10;
  logic clk = 1'b0;
  logic loader_rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic uart_tx, load_busy, load_done, load_err;
  logic [7:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic [8:0] words_loaded;
  int n_tests = 0, n_fail = 0, done_cnt = 0;
  logic [7:0] tx_q[$];
  logic [31:0] ref_mem[256];
  bit known[256];
  logic [31:0] fw[256];
  logic [7:0] mb;

  always #5 clk = ~clk;

  uart_instr_loader #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .INSTR_WIDTH(32),
                      .INSTR_DEPTH(256), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .loader_rst_n(loader_rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .rd_addr(rd_addr), .rd_data(rd_data), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always @(negedge clk) if (load_done) done_cnt++;

  initial forever begin
    @(negedge clk);
    if (uart_tx === 1'b0 && loader_rst_n) begin
      repeat (CPB / 2) @(negedge clk);
      if (uart_tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mb[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx === 1'b1) tx_q.push_back(mb);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic wait_resp(input logic [7:0] exp, input string tag);
    int n;
    logic [7:0] r;
    n = 0;
    r = 8'h00;
    while (tx_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx_q.size() != 0) r = tx_q.pop_front();
    check(tag, 32'(r), 32'(exp));
  endtask

  task automatic readback(input int a);
    rd_addr = 8'(a);
    #1;
    check($sformatf("mem[%0d]", a), rd_data, ref_mem[a]);
  endtask

  task automatic do_frame(input int sa, input int nw, input logic [7:0] chk_xor, input bit glitch);
    logic [7:0] c, b;
    int d0;
    c = 8'h00;
    d0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    check("busy_after_sync", 32'(load_busy), 32'd1);
    check("err_cleared_by_sync", 32'(load_err), 32'd0);
    if (glitch) begin
      uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (30) @(negedge clk);
    end
    send_byte(8'(sa), 1'b1);
    send_byte(8'(nw - 1), 1'b1);
    for (int i = 0; i < nw; i++) begin
      for (int j = 3; j >= 0; j--) begin
        b = fw[i][8*j +: 8];
        send_byte(b, 1'b1);
        c = c ^ b;
      end
      ref_mem[(sa + i) % 256] = fw[i];
      known[(sa + i) % 256] = 1'b1;
    end
    check("busy_before_chk", 32'(load_busy), 32'd1);
    send_byte(c ^ chk_xor, 1'b1);
    wait_resp((chk_xor == 8'h00) ? 8'h4B : 8'h45, "resp");
    check("err", 32'(load_err), (chk_xor != 8'h00) ? 32'd1 : 32'd0);
    check("done_pulses", 32'(done_cnt - d0), (chk_xor == 8'h00) ? 32'd1 : 32'd0);
    check("words_loaded", 32'(words_loaded), 32'(nw));
    check("busy_end", 32'(load_busy), 32'd0);
    for (int i = 0; i < nw; i++) readback((sa + i) % 256);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    loader_rst_n = 1'b1;
    repeat (5) @(negedge clk);

    fw[0] = 32'h80000001; fw[1] = 32'h40000002;
    do_frame(0, 2, 8'h00, 1'b0);
    do_frame(0, 2, 8'hC3, 1'b0);
    fw[0] = 32'h11223344; fw[1] = 32'h55667788;
    do_frame(255, 2, 8'h00, 1'b0);

    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check("garbage_busy", 32'(load_busy), 32'd0);
    check("garbage_no_tx", 32'(tx_q.size()), 32'd0);
    fw[0] = 32'hCAFEF00D;
    do_frame(8'h40, 1, 8'h00, 1'b1);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b0);
    check("ferr_busy", 32'(load_busy), 32'd0);
    check("ferr_err", 32'(load_err), 32'd1);
    wait_resp(8'h45, "ferr_resp");
    check("ferr_words", 32'(words_loaded), 32'd0);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (150) @(negedge clk);
    check("tmo_busy_before", 32'(load_busy), 32'd1);
    repeat (80) @(negedge clk);
    check("tmo_busy_after", 32'(load_busy), 32'd0);
    check("tmo_err", 32'(load_err), 32'd1);
    wait_resp(8'h54, "tmo_resp");
    loader_rst_n = 1'b0;
    #1;
    check("rst_clears_err", 32'(load_err), 32'd0);
    @(negedge clk);
    loader_rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h01, 1'b1);
    foreach (fw[i]) if (i < 4) send_byte(8'hAA + 8'(i * 17), 1'b1);
    ref_mem[32] = 32'hAABBCCDD;
    known[32] = 1'b1;
    send_byte(8'hEE, 1'b1);
    check("pre_rst_words", 32'(words_loaded), 32'd1);
    loader_rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(load_busy), 32'd0);
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_done", 32'(load_done), 32'd0);
    check("midrst_tx", 32'(uart_tx), 32'd1);
    readback(32);
    readback(0);
    repeat (3) @(negedge clk);
    loader_rst_n = 1'b1;
    repeat (20) @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      int sa, nw;
      logic [7:0] x;
      sa = $urandom_range(0, 255);
      nw = $urandom_range(1, 4);
      for (int i = 0; i < nw; i++) fw[i] = $urandom;
      x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      do_frame(sa, nw, x, 1'b0);
    end

    for (int a = 0; a < 256; a++) if (known[a]) readback(a);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_instr_loader.md
Name: uart_instr_loader

Overview:
- Upstream stage of tiny_fsm_control.
- Receives a framed program image over UART and writes 32-bit instruction words into an internal instruction memory.
- Exposes a combinational read port (rd_addr/rd_data) that the control FSM fetches from.
- Returns a one-byte status over uart_tx, and holds load_busy high during a frame so the system can keep the FSM in reset.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide; 434 at defaults).
- INSTR_WIDTH, 32, instruction word width; must be 32 (4 bytes per word).
- INSTR_DEPTH, 256, number of memory words; AW = $clog2(INSTR_DEPTH).
- TIMEOUT_BITS, 20, mid-frame idle limit in bit-times.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- loader_rst_n  input  1  reset, asynchronous assert, active-low.
- uart_rx  input  1  serial in; idle high; 8N1, LSB first.
- uart_tx  output  1  serial out; 8N1; idle high.
- rd_addr  input  AW  read address from the control FSM.
- rd_data  output  INSTR_WIDTH  combinational read, mem[rd_addr].
- load_busy  output  1  high from SYNC accepted until frame end.
- load_done  output  1  one-cycle pulse on a good frame.
- load_err  output  1  sticky; set on a bad frame; cleared by the next SYNC or by reset.
- words_loaded  output  AW+1  words written in the current or last frame.

Behaviour:
- Reset values: uart_tx=1, load_busy=0, load_done=0, load_err=0, words_loaded=0, parser in IDLE, receiver in RX_IDLE. Memory contents are not reset.
- RX front end:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge starts RX_START. The line is re-checked at CLKS_PER_BIT/2; if high, the start is treated as a glitch and the receiver returns to RX_IDLE.
  - Data bits are sampled every CLKS_PER_BIT after that point.
  - Stop bit sampled 0: framing error, byte discarded.
  - A good byte gives a one-cycle rx_valid pulse, rx_data[7:0].
- Frame format: 0xA5 (SYNC), START_ADDR, COUNT, then 4*(COUNT+1) payload bytes (MSB of each word first), then CHK.
  - CHK = XOR of all payload bytes.
  - Word count ranges 1..256.
- Parser FSM states: IDLE, ADDR, COUNT, DATA, CHK, RESP.
  - IDLE: a non-A5 byte is ignored. A5 moves to ADDR; the same cycle sets load_busy=1, clears load_err, clears words_loaded.
  - ADDR: latch wr_addr. Then COUNT: latch remaining = COUNT+1. Then DATA.
  - DATA: shift each byte into a 32-bit assembly register and XOR it into chk_acc. On the 4th byte, write mem[wr_addr] on the next clock edge, wr_addr increments modulo INSTR_DEPTH, words_loaded increments, remaining decrements. When remaining reaches 0, go to CHK.
  - CHK: compare the byte to chk_acc. Match: load_done pulses one cycle, response is 0x4B. Mismatch: load_err=1, response is 0x45. Then RESP.
  - RESP: launch the TX byte, drop load_busy, return to IDLE the same cycle.
- Words are committed as they arrive. A checksum failure does not roll back memory; the host must reload.
- Write/read: a write on edge N is visible on rd_data combinationally after edge N. A read and a write to the same address in the same cycle returns the old data.
- Errors mid-frame (states ADDR..CHK):
  - Framing error, or no byte for TIMEOUT_BITS*CLKS_PER_BIT clocks: load_err=1, load_busy=0, return to IDLE.
  - The TX response is 0x45 for a framing error and 0x54 for a timeout.
  - A framing error in IDLE is ignored silently.
- TX: standard 8N1 shifter, one byte buffered. If a response is requested while TX is busy, the new response is dropped; the flags still update.
- Reset mid-frame: everything returns to reset values immediately. Partially written memory is retained. A TX byte in flight is truncated and the line is forced high.
- The parser stays open during RESP, so a SYNC arriving while TX is still sending starts a new frame normally.

Test Plan:
- Use CLK_FREQ=1000000, BAUD_RATE=100000 (CLKS_PER_BIT=10).
- Good frame: A5,00,01,80,00,00,01,40,00,00,02,CHK=C3 -> mem[0]=80000001, mem[1]=40000002, load_done single pulse, words_loaded=2, uart_tx byte 0x4B, load_busy high from A5 stop bit through CHK.
- Bad checksum: same frame with CHK=00 -> mem[0..1] still written, load_err=1, TX 0x45, no load_done; a following good frame clears load_err.
- Wrap-around: START_ADDR=FF, COUNT=01, words 11223344 and 55667788 -> mem[255]=11223344, mem[0]=55667788.
- Robustness: garbage bytes 00,FF,5A before A5 are ignored. A 4-clock low glitch on idle uart_rx produces no byte. A stop bit driven 0 mid-DATA gives load_err=1 and TX 0x45.
- Timeout, then reset: stop sending after the 2nd payload byte -> after 200 clocks load_busy=0, TX 0x54. Assert loader_rst_n low mid-frame -> all outputs return to reset values within the same cycle, and rd_data still shows previously written words.
